// File: rtl/y86_pkg.sv
// Shared Y86 encodings for the execute stage: icodes, ALU and condition ifuns,
// one-hot stat codes, the "no register" id and the multiply FSM state type.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;
    localparam logic [3:0] ALU_MUL = 4'h4;

    localparam logic [3:0] C_ALWAYS = 4'h0;
    localparam logic [3:0] C_LE     = 4'h1;
    localparam logic [3:0] C_L      = 4'h2;
    localparam logic [3:0] C_E      = 4'h3;
    localparam logic [3:0] C_NE     = 4'h4;
    localparam logic [3:0] C_GE     = 4'h5;
    localparam logic [3:0] C_G      = 4'h6;

    localparam logic [3:0] STAT_AOK = 4'b1000;
    localparam logic [3:0] STAT_HLT = 4'b0100;
    localparam logic [3:0] STAT_ADR = 4'b0010;
    localparam logic [3:0] STAT_INS = 4'b0001;

    localparam logic [3:0] RNONE = 4'hF;

    typedef logic [1:0] exec_state_t;
    localparam exec_state_t ST_IDLE = 2'd0;
    localparam exec_state_t ST_MUL  = 2'd1;
    localparam exec_state_t ST_DONE = 2'd2;

endpackage

// File: rtl/y86_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle. Only the low
// DATA_W bits of the product are kept, which is correct for two's complement.
module y86_mul_iter #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_busy,
    output logic              o_done,
    output logic [DATA_W-1:0] o_product
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0] r_mplier;
    logic [DATA_W-1:0] r_acc;
    logic              r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_busy   <= 1'b0;
        end else if (i_abort) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_cnt    <= CNT_W'(DATA_W);
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_acc    <= '0;
            r_busy   <= 1'b1;
        end else if (r_busy) begin
            if (r_mplier[0])
                r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt - CNT_W'(1);
            if (r_cnt == CNT_W'(1))
                r_busy <= 1'b0;
        end
    end

    // done marks the cycle whose closing edge performs the final step
    assign o_busy    = r_busy;
    assign o_done    = r_busy && (r_cnt == CNT_W'(1));
    assign o_product = r_acc;

endmodule

// File: rtl/y86_execute_mc.sv
// Multi-cycle Y86 execute stage: ALU, branch/cmov conditions and the CC register.
// Define Y86_EXEC_MUL_EN to build the iterative OPq multiply (ifun 4).
module y86_execute_mc #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              E_valid,
    input  logic [3:0]        E_stat,
    input  logic [3:0]        E_icode,
    input  logic [3:0]        E_ifun,
    input  logic [DATA_W-1:0] E_valA,
    input  logic [DATA_W-1:0] E_valB,
    input  logic [DATA_W-1:0] E_valC,
    input  logic [3:0]        E_dstE,
    input  logic [3:0]        E_dstM,
    input  logic [3:0]        m_stat,
    input  logic [3:0]        W_stat,
    output logic [3:0]        e_stat,
    output logic [3:0]        e_icode,
    output logic              e_Cnd,
    output logic [DATA_W-1:0] e_valE,
    output logic [DATA_W-1:0] e_valA,
    output logic [3:0]        e_dstE,
    output logic [3:0]        e_dstM,
    output logic              e_valid,
    output logic              e_busy,
    output logic              ZF,
    output logic              SF,
    output logic              OF
);
    import y86_pkg::*;

    localparam int MSB = DATA_W - 1;
    localparam logic [DATA_W-1:0] W_EIGHT = DATA_W'(8);

    logic              w_is_op;
    logic              w_mul_ok;
    logic              w_illegal;
    logic              w_cond;
    logic              w_of;
    logic              w_cc_we;
    logic [DATA_W-1:0] w_alu;

    assign w_is_op   = (E_icode == I_OPQ);
    assign w_illegal = w_is_op && ((E_ifun > ALU_MUL) || ((E_ifun == ALU_MUL) && !w_mul_ok));

    always_comb begin
        w_alu = '0;
        case (E_icode)
            I_RRMOVQ:           w_alu = E_valA;
            I_IRMOVQ:           w_alu = E_valC;
            I_RMMOVQ, I_MRMOVQ: w_alu = E_valB + E_valC;
            I_CALL, I_PUSHQ:    w_alu = E_valB - W_EIGHT;
            I_RET, I_POPQ:      w_alu = E_valB + W_EIGHT;
            I_OPQ: begin
                case (E_ifun)
                    ALU_ADD: w_alu = E_valB + E_valA;
                    ALU_SUB: w_alu = E_valB - E_valA;
                    ALU_AND: w_alu = E_valB & E_valA;
                    ALU_XOR: w_alu = E_valB ^ E_valA;
                    default: w_alu = '0;
                endcase
            end
            default:            w_alu = '0;
        endcase
    end

    always_comb begin
        w_cond = 1'b0;
        case (E_ifun)
            C_ALWAYS: w_cond = 1'b1;
            C_LE:     w_cond = (SF ^ OF) | ZF;
            C_L:      w_cond = SF ^ OF;
            C_E:      w_cond = ZF;
            C_NE:     w_cond = ~ZF;
            C_GE:     w_cond = ~(SF ^ OF);
            C_G:      w_cond = ~(SF ^ OF) & ~ZF;
            default:  w_cond = 1'b0;
        endcase
    end

    always_comb begin
        w_of = 1'b0;
        case (E_ifun)
            ALU_ADD: w_of = (E_valA[MSB] == E_valB[MSB]) && (w_alu[MSB] != E_valB[MSB]);
            ALU_SUB: w_of = (E_valA[MSB] != E_valB[MSB]) && (w_alu[MSB] != E_valB[MSB]);
            default: w_of = 1'b0;
        endcase
    end

`ifdef Y86_EXEC_MUL_EN
    exec_state_t       r_state;
    logic              w_start;
    logic              w_abort;
    logic              w_mul_busy;
    logic              w_mul_done;
    logic [DATA_W-1:0] w_prod;

    assign w_mul_ok = 1'b1;
    assign w_start  = (r_state == ST_IDLE) && E_valid && w_is_op && (E_ifun == ALU_MUL);
    assign w_abort  = (r_state != ST_IDLE) && !E_valid;

    // A dropped E_valid in MUL or DONE is a flush: abandon the multiply
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_start) r_state <= ST_MUL;
                ST_MUL:  begin
                    if (!E_valid)
                        r_state <= ST_IDLE;
                    else if (w_mul_done)
                        r_state <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    y86_mul_iter #(.DATA_W(DATA_W)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_start),
        .i_abort   (w_abort),
        .i_a       (E_valA),
        .i_b       (E_valB),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_prod)
    );

    assign e_busy  = w_start || w_mul_busy;
    assign e_valid = E_valid && !e_busy;
    assign e_valE  = (r_state == ST_DONE) ? w_prod : w_alu;
`else
    assign w_mul_ok = 1'b0;
    assign e_busy   = 1'b0;
    assign e_valid  = E_valid;
    assign e_valE   = w_alu;
`endif

    assign e_stat  = w_illegal ? STAT_INS : E_stat;
    assign e_icode = E_icode;
    assign e_Cnd   = ((E_icode == I_JXX) || (E_icode == I_RRMOVQ)) ? w_cond : 1'b0;
    assign e_valA  = E_valA;
    assign e_dstM  = E_dstM;
    assign e_dstE  = (w_illegal || ((E_icode == I_RRMOVQ) && !w_cond)) ? RNONE : E_dstE;

    // Only a committed, exception-free OPq may touch the flags
    assign w_cc_we = w_is_op && e_valid && (e_stat == STAT_AOK)
                     && (m_stat == STAT_AOK) && (W_stat == STAT_AOK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ZF <= 1'b1;
            SF <= 1'b0;
            OF <= 1'b0;
        end else if (w_cc_we) begin
            ZF <= (e_valE == '0);
            SF <= e_valE[MSB];
            OF <= w_of;
        end
    end

endmodule

// File: tb/tb_y86_execute_mc.sv
// Self-checking bench for y86_execute_mc (DATA_W = 64): directed flag/branch
// cases, multiply (when Y86_EXEC_MUL_EN is defined) and a randomized sweep.
module tb_y86_execute_mc;

    localparam logic [3:0] AOK = 4'b1000;
    localparam logic [3:0] HLT = 4'b0100;
    localparam logic [3:0] ADR = 4'b0010;
    localparam logic [3:0] INS = 4'b0001;
`ifdef Y86_EXEC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        E_valid;
    logic [3:0]  E_stat, E_icode, E_ifun, E_dstE, E_dstM, m_stat, W_stat;
    logic [63:0] E_valA, E_valB, E_valC;
    logic [3:0]  e_stat, e_icode, e_dstE, e_dstM;
    logic        e_Cnd, e_valid, e_busy, ZF, SF, OF;
    logic [63:0] e_valE, e_valA;

    int nChecks = 0;
    int nPass = 0;
    int busyCycles;
    logic mZF, mSF, mOF;
    logic nZF, nSF, nOF, nUpd;

    y86_execute_mc #(.DATA_W(64)) dut (
        .clk(clk), .rst_n(rst_n), .E_valid(E_valid), .E_stat(E_stat),
        .E_icode(E_icode), .E_ifun(E_ifun), .E_valA(E_valA), .E_valB(E_valB),
        .E_valC(E_valC), .E_dstE(E_dstE), .E_dstM(E_dstM), .m_stat(m_stat),
        .W_stat(W_stat), .e_stat(e_stat), .e_icode(e_icode), .e_Cnd(e_Cnd),
        .e_valE(e_valE), .e_valA(e_valA), .e_dstE(e_dstE), .e_dstM(e_dstM),
        .e_valid(e_valid), .e_busy(e_busy), .ZF(ZF), .SF(SF), .OF(OF)
    );

    always #5 clk = ~clk;

    // Reference: valE per instruction class
    function automatic logic [63:0] refValE(input logic [3:0] ic, input logic [3:0] fn,
                                            input logic [63:0] a, input logic [63:0] b,
                                            input logic [63:0] c);
        case (ic)
            4'h2:       return a;
            4'h3:       return c;
            4'h4, 4'h5: return b + c;
            4'h8, 4'hA: return b - 64'd8;
            4'h9, 4'hB: return b + 64'd8;
            4'h6: begin
                case (fn)
                    4'h0:    return b + a;
                    4'h1:    return b - a;
                    4'h2:    return b & a;
                    4'h3:    return b ^ a;
                    default: return 64'd0;
                endcase
            end
            default:    return 64'd0;
        endcase
    endfunction

    // Reference: branch/cmov condition from the modelled flags
    function automatic logic refCond(input logic [3:0] fn);
        logic less;
        less = (mSF != mOF);
        case (fn)
            4'h0:    return 1'b1;
            4'h1:    return less || mZF;
            4'h2:    return less;
            4'h3:    return mZF;
            4'h4:    return !mZF;
            4'h5:    return !less;
            4'h6:    return !less && !mZF;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic refIllegal();
        return (E_icode == 4'h6) && ((E_ifun >= 4'h5) || ((E_ifun == 4'h4) && !MUL_EN));
    endfunction

    task automatic applyStimulus(input logic v, input logic [3:0] st, input logic [3:0] ic,
                                 input logic [3:0] fn, input logic [63:0] a,
                                 input logic [63:0] b, input logic [63:0] c,
                                 input logic [3:0] dE, input logic [3:0] ms,
                                 input logic [3:0] ws);
        E_valid = v; E_stat = st; E_icode = ic; E_ifun = fn;
        E_valA = a; E_valB = b; E_valC = c;
        E_dstE = dE; E_dstM = 4'h5; m_stat = ms; W_stat = ws;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Compare every combinational output against the model for the current inputs
    task automatic checkComb();
        logic cnd, ill;
        ill = refIllegal();
        cnd = ((E_icode == 4'h2) || (E_icode == 4'h7)) ? refCond(E_ifun) : 1'b0;
        checkOutput("valE", e_valE, refValE(E_icode, E_ifun, E_valA, E_valB, E_valC));
        checkOutput("cnd", e_Cnd, cnd);
        checkOutput("dstE", e_dstE, (ill || (E_icode == 4'h2 && !cnd)) ? 4'hF : E_dstE);
        checkOutput("stat", e_stat, ill ? INS : E_stat);
        checkOutput("valid", e_valid, E_valid);
        checkOutput("busy", e_busy, 1'b0);
        checkOutput("valA", e_valA, E_valA);
    endtask

    // Compute the model's next flags, clock once, compare the CC register
    task automatic advance();
        logic [63:0] r;
        logic signed [64:0] wide;
        r = refValE(E_icode, E_ifun, E_valA, E_valB, E_valC);
        nUpd = (E_icode == 4'h6) && E_valid && !refIllegal() && (E_stat == AOK)
               && (m_stat == AOK) && (W_stat == AOK);
        nZF = mZF; nSF = mSF; nOF = mOF;
        if (nUpd) begin
            nZF = (r == 64'd0);
            nSF = r[63];
            nOF = 1'b0;
            if (E_ifun == 4'h0) begin
                wide = $signed({E_valB[63], E_valB}) + $signed({E_valA[63], E_valA});
                nOF = (wide > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < -65'sh0_8000_0000_0000_0000);
            end else if (E_ifun == 4'h1) begin
                wide = $signed({E_valB[63], E_valB}) - $signed({E_valA[63], E_valA});
                nOF = (wide > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < -65'sh0_8000_0000_0000_0000);
            end
        end
        @(posedge clk);
        #1;
        mZF = nZF; mSF = nSF; mOF = nOF;
        checkOutput("ZF", ZF, mZF);
        checkOutput("SF", SF, mSF);
        checkOutput("OF", OF, mOF);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b1, AOK, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, AOK, AOK);
        mZF = 1'b1; mSF = 1'b0; mOF = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ZF", ZF, 1'b1);
        checkOutput("rst_SF", SF, 1'b0);
        checkOutput("rst_OF", OF, 1'b0);
        checkOutput("rst_busy", e_busy, 1'b0);
        checkOutput("rst_valid", e_valid, 1'b1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(1'b1, AOK, 4'h7, 4'h4, 64'd0, 64'd0, 64'h40, 4'hF, AOK, AOK);
        @(negedge clk); checkComb(); checkOutput("jne_after_rst", e_Cnd, 1'b0); advance();
        applyStimulus(1'b1, AOK, 4'h7, 4'h0, 64'd0, 64'd0, 64'h40, 4'hF, AOK, AOK);
        @(negedge clk); checkComb(); checkOutput("jmp", e_Cnd, 1'b1); advance();

        applyStimulus(1'b1, AOK, 4'h6, 4'h0, 64'd1, 64'd2, 64'd0, 4'h3, AOK, AOK);
        @(negedge clk); checkComb(); advance();
        checkOutput("add_1_2_ZF", ZF, 1'b0);
        applyStimulus(1'b1, AOK, 4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h3, HLT, AOK);
        @(negedge clk); checkComb(); checkOutput("sub_valE", e_valE, 64'd0); advance();
        checkOutput("sub_mhlt_ZF_hold", ZF, 1'b0);
        applyStimulus(1'b1, AOK, 4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h3, AOK, AOK);
        @(negedge clk); checkComb(); advance();
        checkOutput("sub_ZF_set", ZF, 1'b1);

        applyStimulus(1'b1, AOK, 4'h6, 4'h0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h3, AOK, AOK);
        @(negedge clk); checkComb();
        checkOutput("ovf_valE", e_valE, 64'h8000_0000_0000_0000); advance();
        checkOutput("ovf_SF", SF, 1'b1);
        checkOutput("ovf_OF", OF, 1'b1);
        applyStimulus(1'b1, AOK, 4'h7, 4'h2, 64'd0, 64'd0, 64'h80, 4'hF, AOK, AOK);
        @(negedge clk); checkComb(); checkOutput("jl_after_ovf", e_Cnd, 1'b0); advance();

        applyStimulus(1'b1, AOK, 4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h3, AOK, AOK);
        @(negedge clk); checkComb(); advance();
        applyStimulus(1'b1, AOK, 4'h2, 4'h2, 64'd9, 64'd0, 64'd0, 4'h3, AOK, AOK);
        @(negedge clk); checkComb();
        checkOutput("cmovl_nt_cnd", e_Cnd, 1'b0);
        checkOutput("cmovl_nt_dstE", e_dstE, 4'hF); advance();
        applyStimulus(1'b1, AOK, 4'h6, 4'h0, 64'd1, -64'sd5, 64'd0, 4'h3, AOK, AOK);
        @(negedge clk); checkComb(); advance();
        applyStimulus(1'b1, AOK, 4'h2, 4'h2, 64'd9, 64'd0, 64'd0, 4'h3, AOK, AOK);
        @(negedge clk); checkComb();
        checkOutput("cmovl_t_cnd", e_Cnd, 1'b1);
        checkOutput("cmovl_t_dstE", e_dstE, 4'h3); advance();

        applyStimulus(1'b1, AOK, 4'hA, 4'h0, 64'd7, 64'h100, 64'd0, 4'h4, AOK, AOK);
        @(negedge clk); checkComb(); checkOutput("pushq_valE", e_valE, 64'hF8); advance();

`ifdef Y86_EXEC_MUL_EN
        applyStimulus(1'b1, AOK, 4'h6, 4'h4, 64'd7, -64'sd3, 64'd0, 4'h2, AOK, AOK);
        @(negedge clk);
        checkOutput("mul_busy_c0", e_busy, 1'b1);
        checkOutput("mul_valid_c0", e_valid, 1'b0);
        busyCycles = 1;
        for (int k = 0; k < 200 && e_busy; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (e_busy) busyCycles++;
        end
        checkOutput("mul_busy_cycles", busyCycles, 65);
        checkOutput("mul_valid_done", e_valid, 1'b1);
        checkOutput("mul_valE", e_valE, 64'hFFFF_FFFF_FFFF_FFEB);
        @(posedge clk); #1;
        applyStimulus(1'b1, AOK, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, AOK, AOK);
        mZF = 1'b0; mSF = 1'b1; mOF = 1'b0;
        checkOutput("mul_ZF", ZF, 1'b0);
        checkOutput("mul_SF", SF, 1'b1);
        checkOutput("mul_OF", OF, 1'b0);

        applyStimulus(1'b1, AOK, 4'h6, 4'h4, 64'd3, 64'd3, 64'd0, 4'h2, AOK, AOK);
        repeat (10) @(posedge clk);
        #1;
        E_valid = 1'b0;
        @(negedge clk);
        checkOutput("flush_busy_mul", e_busy, 1'b1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("flush_busy_idle", e_busy, 1'b0);
        checkOutput("flush_valid", e_valid, 1'b0);
        checkOutput("flush_ZF", ZF, mZF);
        checkOutput("flush_SF", SF, mSF);
        @(posedge clk); #1;
        applyStimulus(1'b1, AOK, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, AOK, AOK);
`else
        applyStimulus(1'b1, AOK, 4'h6, 4'h4, 64'd5, 64'd3, 64'd0, 4'h2, AOK, AOK);
        @(negedge clk); checkComb();
        checkOutput("mul_off_stat", e_stat, INS);
        checkOutput("mul_off_busy", e_busy, 1'b0);
        advance();
`endif

        for (int i = 0; i < 30; i++) begin
            logic [3:0] ic, fn, st, ms, ws;
            logic [3:0] stTab [3];
            stTab[0] = AOK; stTab[1] = HLT; stTab[2] = ADR;
            ic = 4'($urandom_range(0, 11));
            fn = 4'($urandom_range(0, 7));
            if (ic == 4'h6 && fn == 4'h4) fn = 4'h1;
            st = ($urandom_range(0, 7) == 0) ? stTab[$urandom_range(1, 2)] : AOK;
            ms = ($urandom_range(0, 7) == 0) ? HLT : AOK;
            ws = ($urandom_range(0, 7) == 0) ? ADR : AOK;
            applyStimulus($urandom_range(0, 7) != 0, st, ic, fn,
                          {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                          4'($urandom_range(0, 14)), ms, ws);
            @(negedge clk); checkComb(); advance();
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/y86_execute_mc.md
# y86_execute_mc

Parametrised, multi-cycle execute stage for the pipelined Y86 processor. It sits between the E and M pipeline registers. It computes valE, evaluates branch and cmov conditions, and owns the condition-code register. Compared with the single-cycle stage, it adds a configurable datapath width, an explicit valid/busy handshake, reset of the condition codes, and an optional iterative multiply (OPq ifun 4) that stalls the pipeline while it runs.

## Interface
- DATA_W, 64, datapath width in bits; minimum 16
- clk  in  1  pipeline clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- E_valid  in  1  E register holds a live instruction; 0 means bubble or flush
- E_stat, E_icode, E_ifun  in  4 each  E register status and opcode fields
- E_valA, E_valB, E_valC  in  DATA_W  operands (signed)
- E_dstE, E_dstM  in  4  destination registers
- m_stat, W_stat  in  4  status of the downstream stages (for CC gating)
- e_stat, e_icode  out  4  status and icode forwarded to M; e_stat becomes INS for an illegal ifun
- e_Cnd  out  1  condition result for jXX/cmovXX; 0 for all other icodes
- e_valE, e_valA  out  DATA_W  ALU result and pass-through valA
- e_dstE, e_dstM  out  4  e_dstE is forced to RNONE (4'hF) on a not-taken cmov
- e_valid  out  1  outputs are final and M may latch them
- e_busy  out  1  stall request; while high, E and earlier stages hold
- ZF, SF, OF  out  1  condition-code register

## Operation
- Stat encoding is one-hot: AOK 4'b1000, HLT 4'b0100, ADR 4'b0010, INS 4'b0001.
- Single-cycle ops are combinational from the E fields, with e_valid = E_valid and e_busy = 0:
  - cmov/irmovq: valE = valA + 0 or valC + 0
  - rmmovq/mrmovq: valE = valB + valC
  - call/pushq: valE = valB − 8
  - ret/popq: valE = valB + 8
  - OPq ifun 0–3: valB+valA, valB−valA, valB&valA, valB^valA
  - All other icodes: valE = 0
- Conditions: ifun 0 always true; 1 le, 2 l, 3 e, 4 ne, 5 ge, 6 g, evaluated from the current CC register. ifun > 6 → e_Cnd = 0.
- OPq ifun ≥ 5, or ifun 4 with the multiplier compiled out → e_stat = INS, e_dstE = RNONE, no CC update.
- FSM states are IDLE, MUL and DONE.
  - IDLE → MUL when E_valid and the instruction is OPq ifun 4. Operands are captured and e_busy = 1.
  - MUL does one shift-add step per cycle for DATA_W cycles. e_busy = 1 and e_valid = 0 throughout.
  - MUL → DONE after step DATA_W. In DONE, e_valE = low DATA_W bits of the product, e_valid = 1 and e_busy = 0.
  - DONE → IDLE on the next edge.
- Flush: E_valid low during MUL or DONE → IDLE on the next edge, no CC update, result discarded.
- CC update happens on the edge where icode is OPq, e_valid = 1, e_stat = AOK, m_stat = AOK and W_stat = AOK. Then:
  - ZF = (valE == 0) and SF = valE[DATA_W−1].
  - OF for add: operands have the same sign and the result sign differs.
  - OF for sub: the signs of valB and valA differ and the result sign differs from valB.
  - OF = 0 for and, xor and mul.
- The constants ±8 are sign-extended to DATA_W.

## Timing
- Reset values: FSM IDLE, ZF = 1, SF = 0, OF = 0, multiplier registers 0, e_busy = 0, e_valid = E_valid (combinational).
- Latency: single-cycle ops have 0 registered latency, same as before.
- mul: accepted in cycle 0, e_busy high in cycles 0..DATA_W, result valid in cycle DATA_W+1. Total DATA_W+2 cycles occupancy.
- A new instruction is accepted in IDLE only. Upstream must hold the E fields stable while e_busy = 1.
- Reset asserted mid-MUL aborts immediately. The CC keeps its reset values.
- CC written in cycle N is visible to a jXX/cmov in cycle N+1.

## Configuration
- Y86_EXEC_MUL_EN defined: OPq ifun 4 is a DATA_W-cycle iterative multiply, with the FSM and the y86_mul_iter instance present.
- Undefined: no FSM or multiplier is built. e_busy is tied to 0. OPq ifun 4 produces INS.

## Structure
- Package y86_pkg holds:
  - icode localparams (NOP..POPQ)
  - ALU ifun codes (ADD, SUB, AND, XOR, MUL)
  - condition ifun codes
  - stat one-hot constants
  - RNONE
  - the FSM state typedef
- One sub-module, y86_mul_iter (DATA_W param): start/busy/done handshake and a shift-add loop, one bit per cycle.

## Test plan
- After reset: ZF/SF/OF = 1/0/0. jne with ifun 4 → e_Cnd = 0. jmp → e_Cnd = 1.
- OPq sub, valB = 5, valA = 5, all stats AOK → valE = 0; ZF = 1 next cycle. With m_stat = HLT instead, the CC is unchanged.
- OPq add, 0x7FFF_FFFF_FFFF_FFFF + 1 → valE = 0x8000_0000_0000_0000; SF = 1, OF = 1. A following jl → e_Cnd = 0.
- cmovl with SF = 0, OF = 0 → e_Cnd = 0 and e_dstE = 4'hF. With SF = 1 → e_dstE = E_dstE.
- With mul enabled and DATA_W = 64: 7 × −3 → e_busy high for 65 cycles, then e_valid with valE = −21, SF = 1, OF = 0. Dropping E_valid mid-MUL → IDLE and the CC is unchanged.
- With mul disabled: OPq ifun 4 → e_stat = INS, e_busy = 0, CC unchanged. pushq with valB = 0x100 → valE = 0xF8.
